fetch_unit: RTL and testbench

//  Parametrised instruction-fetch stage: PC register, next-PC select (seq/branch/j/jr), and a

---
 rtl/fetch_unit_pkg.sv | 27 ++
 rtl/fetch_unit_if.sv | 34 +++
 rtl/fetch_unit_queue.sv | 85 ++++++++
 rtl/fetch_unit.sv | 138 +++++++++++++
 tb/tb_fetch_unit.sv | 396 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_pkg
// Desc     : Shared constants and jump-target helper for the fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

    localparam logic [1:0] JSEL_SEQ = 2'b00;
    localparam logic [1:0] JSEL_J   = 2'b01;
    localparam logic [1:0] JSEL_JR  = 2'b10;
    localparam logic [1:0] JSEL_RSV = 2'b11;

    // Width-generic j target: upper bits of PC+4, immediate, two zero bits.
    // Callers truncate the 64-bit result to their own XLEN.
    function automatic logic [63:0] j_target(input logic [63:0] pc4,
                                             input logic [63:0] jaddr,
                                             input int unsigned  jaddr_w);
        logic [63:0] upper_mask;
        logic [63:0] low_mask;
        upper_mask = ~64'd0 << (jaddr_w + 2);
        low_mask   = (64'd1 << jaddr_w) - 64'd1;
        return (pc4 & upper_mask) | ((jaddr & low_mask) << 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_if
// Desc     : imem request/response and ID delivery handshakes of the fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_instr;
    logic [XLEN-1:0] id_pc4;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output id_valid, id_instr, id_pc4,
        input  id_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  id_valid, id_instr, id_pc4,
        output id_ready
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_queue
// Desc     : In-order circular fetch queue; entries are allocated at issue and
//            filled later by in-order imem responses.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit_queue #(
    parameter  int XLEN     = 32,
    parameter  int FQ_DEPTH = 4,
    localparam int PTR_W    = $clog2(FQ_DEPTH),
    localparam int CNT_W    = PTR_W + 1
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            flush_i,
    input  wire logic            alloc_i,
    input  wire logic [XLEN-1:0] alloc_pc4_i,
    input  wire logic            fill_i,
    input  wire logic [XLEN-1:0] fill_data_i,
    input  wire logic            pop_i,
    output logic                 head_filled_o,
    output logic [XLEN-1:0]      head_instr_o,
    output logic [XLEN-1:0]      head_pc4_o,
    output logic [CNT_W-1:0]     occ_o,
    output logic [CNT_W-1:0]     unfilled_o
);

    logic [XLEN-1:0]     pc4_q   [FQ_DEPTH];
    logic [XLEN-1:0]     instr_q [FQ_DEPTH];
    logic [FQ_DEPTH-1:0] filled_q;
    logic [PTR_W-1:0]    head_q;
    logic [PTR_W-1:0]    tail_q;
    logic [PTR_W-1:0]    fill_q;
    logic [CNT_W-1:0]    occ_q;
    logic [CNT_W-1:0]    unfilled_q;

    // The fill pointer always names an allocated-but-unfilled entry, so it never
    // collides with the tail (free slot) or a poppable (filled) head.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FQ_DEPTH; i++) begin
                pc4_q[i]   <= '0;
                instr_q[i] <= '0;
            end
            filled_q   <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            fill_q     <= '0;
            occ_q      <= '0;
            unfilled_q <= '0;
        end else if (flush_i) begin
            filled_q   <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            fill_q     <= '0;
            occ_q      <= '0;
            unfilled_q <= '0;
        end else begin
            if (alloc_i) begin
                pc4_q[tail_q]    <= alloc_pc4_i;
                filled_q[tail_q] <= 1'b0;
                tail_q           <= tail_q + PTR_W'(1);
            end
            if (fill_i) begin
                instr_q[fill_q]  <= fill_data_i;
                filled_q[fill_q] <= 1'b1;
                fill_q           <= fill_q + PTR_W'(1);
            end
            if (pop_i) begin
                head_q <= head_q + PTR_W'(1);
            end
            occ_q      <= occ_q + CNT_W'(alloc_i) - CNT_W'(pop_i);
            unfilled_q <= unfilled_q + CNT_W'(alloc_i) - CNT_W'(fill_i);
        end
    end

    assign head_filled_o = (occ_q != '0) && filled_q[head_q];
    assign head_instr_o  = instr_q[head_q];
    assign head_pc4_o    = pc4_q[head_q];
    assign occ_o         = occ_q;
    assign unfilled_o    = unfilled_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Desc     : Instruction fetch stage: PC, next-PC select, credit-limited imem
//            issue, wrong-path response dropping and a fetch queue towards ID.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              JADDR_W  = 26,
    parameter int              FQ_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               br_taken_i,
    input  wire logic [XLEN-1:0]    branch_target_i,
    input  wire logic [1:0]         jmp_sel_i,
    input  wire logic [JADDR_W-1:0] jmp_addr_i,
    input  wire logic [XLEN-1:0]    jmp_pc4_i,
    input  wire logic [XLEN-1:0]    jr_target_i,
    fetch_unit_if.master            bus
);

    localparam int CNT_W = $clog2(FQ_DEPTH) + 1;

    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  pc_d;
    logic [CNT_W-1:0] drop_cnt_q;
    logic [CNT_W-1:0] drop_cnt_d;

    logic [XLEN-1:0]  w_pc4;
    logic [XLEN-1:0]  w_j_target;
    logic [XLEN-1:0]  w_target;
    logic             w_redirect;
    logic             w_credit;
    logic [CNT_W:0]   w_inflight;
    logic             w_req_valid;
    logic             w_fire;
    logic             w_fill;
    logic             w_id_valid;
    logic             w_pop;
    logic             w_head_filled;
    logic [XLEN-1:0]  w_head_instr;
    logic [XLEN-1:0]  w_head_pc4;
    logic [CNT_W-1:0] w_occ;
    logic [CNT_W-1:0] w_unfilled;

    assign w_pc4      = pc_q + XLEN'(4);
    assign w_j_target = XLEN'(j_target(64'(jmp_pc4_i), 64'(jmp_addr_i), JADDR_W));

    always_comb begin
        w_redirect = br_taken_i;
        w_target   = branch_target_i;
        case (jmp_sel_i)
            JSEL_JR: begin
                w_redirect = 1'b1;
                w_target   = jr_target_i;
            end
            JSEL_J: begin
                w_redirect = 1'b1;
                w_target   = w_j_target;
            end
            JSEL_SEQ, JSEL_RSV: ;
            default: ;
        endcase
    end

    // Queue entries plus wrong-path responses still owed by imem share one budget.
    assign w_inflight  = {1'b0, w_occ} + {1'b0, drop_cnt_q};
    assign w_credit    = w_inflight < (CNT_W + 1)'(FQ_DEPTH);
    assign w_req_valid = !rst && !w_redirect && w_credit;
    assign w_fire      = w_req_valid && bus.imem_req_ready;
    assign w_fill      = bus.imem_rsp_valid && (drop_cnt_q == '0) &&
                         (w_unfilled != '0) && !w_redirect;
    assign w_id_valid  = w_head_filled && !w_redirect;
    assign w_pop       = w_id_valid && bus.id_ready;

    always_comb begin
        pc_d = pc_q;
        if (w_redirect) begin
            pc_d = w_target;
        end else if (w_fire) begin
            pc_d = w_pc4;
        end
    end

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (w_redirect) begin
            drop_cnt_d = drop_cnt_q + w_unfilled;
            if (bus.imem_rsp_valid && (drop_cnt_d != '0)) begin
                drop_cnt_d = drop_cnt_d - CNT_W'(1);
            end
        end else if (bus.imem_rsp_valid && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            drop_cnt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    fetch_unit_queue #(
        .XLEN     (XLEN),
        .FQ_DEPTH (FQ_DEPTH)
    ) u_queue (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (w_redirect),
        .alloc_i       (w_fire),
        .alloc_pc4_i   (w_pc4),
        .fill_i        (w_fill),
        .fill_data_i   (bus.imem_rsp_data),
        .pop_i         (w_pop),
        .head_filled_o (w_head_filled),
        .head_instr_o  (w_head_instr),
        .head_pc4_o    (w_head_pc4),
        .occ_o         (w_occ),
        .unfilled_o    (w_unfilled)
    );

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = pc_q;
    assign bus.id_valid       = w_id_valid;
    assign bus.id_instr       = w_head_instr;
    assign bus.id_pc4         = w_head_pc4;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Desc     : Self-checking bench: randomized imem/ID traffic and redirects
//            against a queue-based program-order reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int          XLEN     = 32;
    localparam int          JADDR_W  = 26;
    localparam int          FQ_DEPTH = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        br_taken;
    logic [31:0] branch_target;
    logic [1:0]  jmp_sel;
    logic [25:0] jmp_addr;
    logic [31:0] jmp_pc4;
    logic [31:0] jr_target;

    fetch_unit_if #(.XLEN(XLEN)) bus ();

    fetch_unit #(
        .XLEN     (XLEN),
        .JADDR_W  (JADDR_W),
        .FQ_DEPTH (FQ_DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .br_taken_i      (br_taken),
        .branch_target_i (branch_target),
        .jmp_sel_i       (jmp_sel),
        .jmp_addr_i      (jmp_addr),
        .jmp_pc4_i       (jmp_pc4),
        .jr_target_i     (jr_target),
        .bus             (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
    } req_t;

    // Model: requests owed by imem (tagged with the path they belong to) and
    // correct-path instructions that have arrived but not yet gone to ID.
    req_t        pending[$];
    logic [31:0] buffered[$];
    logic [31:0] m_pc;
    int          epoch;

    int vectors;
    int miscompares;
    int ready_pct;
    int rsp_pct;
    int idr_pct;
    int fire_cnt;
    int pop_cnt;
    logic        last_fire;
    logic [31:0] last_fire_addr;
    logic        last_pop;
    logic [31:0] last_pop_pc4;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // One clock cycle: drive imem/ID, check against the model, advance the model.
    task automatic tick();
        logic        redir;
        logic [31:0] tgt;
        logic        exp_req;
        logic        exp_idv;
        bus.imem_req_ready = ($urandom_range(0, 99) < ready_pct);
        bus.id_ready       = ($urandom_range(0, 99) < idr_pct);
        if (!rst && pending.size() > 0 && $urandom_range(0, 99) < rsp_pct) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = instr_of(pending[0].addr);
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = $urandom;
        end
        #1;
        redir = (jmp_sel == JSEL_J) || (jmp_sel == JSEL_JR) || br_taken;
        if (jmp_sel == JSEL_JR)     tgt = jr_target;
        else if (jmp_sel == JSEL_J) tgt = jmp_pc4 - (jmp_pc4 % 32'h1000_0000) + {6'b0, jmp_addr} * 4;
        else                        tgt = branch_target;

        exp_req = !rst && !redir && (pending.size() + buffered.size() < FQ_DEPTH);
        vectors++;
        if (bus.imem_req_valid !== exp_req) begin
            miscompares++;
            $display("FAIL req_valid t=%0t: got %b expected %b", $time, bus.imem_req_valid, exp_req);
        end
        if (exp_req) begin
            vectors++;
            if (bus.imem_req_addr !== m_pc) begin
                miscompares++;
                $display("FAIL req_addr t=%0t: got %h expected %h", $time, bus.imem_req_addr, m_pc);
            end
        end
        exp_idv = !redir && (buffered.size() > 0);
        vectors++;
        if (bus.id_valid !== exp_idv) begin
            miscompares++;
            $display("FAIL id_valid t=%0t: got %b expected %b", $time, bus.id_valid, exp_idv);
        end
        if (exp_idv) begin
            vectors++;
            if (bus.id_pc4 !== buffered[0] + 32'd4 || bus.id_instr !== instr_of(buffered[0])) begin
                miscompares++;
                $display("FAIL id_data t=%0t: got pc4 %h instr %h expected pc4 %h instr %h",
                         $time, bus.id_pc4, bus.id_instr, buffered[0] + 32'd4, instr_of(buffered[0]));
            end
        end

        last_fire      = bus.imem_req_valid && bus.imem_req_ready;
        last_fire_addr = bus.imem_req_addr;
        last_pop       = bus.id_valid && bus.id_ready;
        last_pop_pc4   = bus.id_pc4;
        if (last_fire) fire_cnt++;
        if (last_pop)  pop_cnt++;

        if (rst) begin
            pending.delete();
            buffered.delete();
            m_pc = RESET_PC;
            epoch++;
        end else begin
            if (bus.imem_rsp_valid && pending.size() > 0) begin
                if (!redir && pending[0].epoch == epoch) buffered.push_back(pending[0].addr);
                void'(pending.pop_front());
            end
            if (exp_idv && bus.id_ready) void'(buffered.pop_front());
            if (redir) begin
                buffered.delete();
                epoch++;
                m_pc = tgt;
            end else if (exp_req && bus.imem_req_ready) begin
                pending.push_back('{addr: m_pc, epoch: epoch});
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
        br_taken = 1'b0;
        jmp_sel  = JSEL_SEQ;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_fire(input string name, input logic [31:0] want);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!last_fire && n < 20);
        vectors++;
        if (!last_fire || last_fire_addr !== want) begin
            miscompares++;
            $display("FAIL %s: fired %b addr %h expected addr %h", name, last_fire, last_fire_addr, want);
        end
    endtask

    task automatic wait_pop(input string name, input logic [31:0] want);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!last_pop && n < 40);
        vectors++;
        if (!last_pop || last_pop_pc4 !== want) begin
            miscompares++;
            $display("FAIL %s: popped %b pc4 %h expected pc4 %h", name, last_pop, last_pop_pc4, want);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        vectors++;
        if (bus.imem_req_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_req_valid: got %b expected 0", bus.imem_req_valid);
        end
        tick();
        rst = 1'b0;
        #1;
        vectors++;
        if (bus.id_valid !== 1'b0 || bus.id_instr !== 32'h0 || bus.id_pc4 !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_id: got valid %b instr %h pc4 %h expected 0 0 0",
                     bus.id_valid, bus.id_instr, bus.id_pc4);
        end
        vectors++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RESET_PC) begin
            miscompares++;
            $display("FAIL reset_first_req: got valid %b addr %h expected 1 %h",
                     bus.imem_req_valid, bus.imem_req_addr, RESET_PC);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_f = 32'h0;
        logic [31:0] exp_p = 32'h4;
        int          start = pop_cnt;
        ready_pct = 100; rsp_pct = 100; idr_pct = 100;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            tick();
            if (last_fire) begin
                vectors++;
                if (last_fire_addr !== exp_f) begin
                    miscompares++;
                    $display("FAIL seq_req_addr: got %h expected %h", last_fire_addr, exp_f);
                end
                exp_f = exp_f + 32'd4;
            end
            if (last_pop) begin
                vectors++;
                if (last_pop_pc4 !== exp_p) begin
                    miscompares++;
                    $display("FAIL seq_id_pc4: got %h expected %h", last_pop_pc4, exp_p);
                end
                exp_p = exp_p + 32'd4;
            end
        end
        vectors++;
        if (pop_cnt - start < 8) begin
            miscompares++;
            $display("FAIL seq_throughput: got %0d pops expected at least 8", pop_cnt - start);
        end
    endtask

    task automatic test_stall();
        ready_pct = 100; rsp_pct = 100; idr_pct = 0;
        do_reset();
        fire_cnt = 0;
        repeat (10) tick();
        vectors++;
        if (fire_cnt !== FQ_DEPTH || bus.imem_req_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_credits: got %0d issued req_valid %b expected %0d issued req_valid 0",
                     fire_cnt, bus.imem_req_valid, FQ_DEPTH);
        end
        vectors++;
        if (bus.id_valid !== 1'b1 || bus.id_pc4 !== 32'h4) begin
            miscompares++;
            $display("FAIL stall_hold: got valid %b pc4 %h expected 1 00000004", bus.id_valid, bus.id_pc4);
        end
        idr_pct = 100;
        for (int k = 0; k < 4; k++) begin
            tick();
            vectors++;
            if (!last_pop || last_pop_pc4 !== 32'(4 * (k + 1))) begin
                miscompares++;
                $display("FAIL stall_release: got pop %b pc4 %h expected pop 1 pc4 %h",
                         last_pop, last_pop_pc4, 32'(4 * (k + 1)));
            end
        end
    endtask

    task automatic test_branch();
        ready_pct = 100; rsp_pct = 0; idr_pct = 100;
        do_reset();
        tick();
        tick();
        ready_pct     = 0;
        br_taken      = 1'b1;
        branch_target = 32'h100;
        tick();
        ready_pct = 100; rsp_pct = 100;
        wait_fire("branch_req_addr", 32'h100);
        wait_pop("branch_first_pc4", 32'h104);
    endtask

    task automatic test_jump();
        ready_pct = 100; rsp_pct = 100; idr_pct = 100;
        jmp_sel  = JSEL_J;
        jmp_addr = 26'h000_0040;
        jmp_pc4  = 32'h3000_0010;
        tick();
        wait_fire("jump_req_addr", 32'h3000_0100);
        wait_pop("jump_first_pc4", 32'h3000_0104);
    endtask

    task automatic test_jr_priority();
        logic [31:0] prev;
        ready_pct = 100; rsp_pct = 100; idr_pct = 100;
        jmp_sel       = JSEL_JR;
        br_taken      = 1'b1;
        jr_target     = 32'h200;
        branch_target = 32'h100;
        tick();
        wait_fire("jr_priority_req_addr", 32'h200);
        repeat (4) tick();
        prev    = last_fire_addr;
        jmp_sel = JSEL_RSV;
        tick();
        vectors++;
        if (!last_fire || last_fire_addr !== prev + 32'd4) begin
            miscompares++;
            $display("FAIL jsel_reserved: got fire %b addr %h expected fire 1 addr %h",
                     last_fire, last_fire_addr, prev + 32'd4);
        end
    endtask

    task automatic test_reset_mid_and_wrap();
        int n = 0;
        ready_pct = 100; rsp_pct = 100; idr_pct = 0;
        while (buffered.size() < 3 && n < 20) begin
            tick();
            n++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        vectors++;
        if (bus.id_valid !== 1'b0 || bus.imem_req_addr !== RESET_PC || bus.id_pc4 !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_mid: got id_valid %b addr %h pc4 %h expected 0 %h 0",
                     bus.id_valid, bus.imem_req_addr, bus.id_pc4, RESET_PC);
        end
        idr_pct   = 100;
        jmp_sel   = JSEL_JR;
        jr_target = 32'hFFFF_FFFC;
        tick();
        wait_fire("wrap_last_addr", 32'hFFFF_FFFC);
        wait_fire("wrap_zero_addr", 32'h0000_0000);
    endtask

    task automatic test_random();
        int start = pop_cnt;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                ready_pct = $urandom_range(30, 100);
                rsp_pct   = $urandom_range(30, 100);
                idr_pct   = $urandom_range(30, 100);
            end
            if ($urandom_range(0, 999) < 5) begin
                rst = 1'b1;
            end else if ($urandom_range(0, 99) < 6) begin
                jmp_sel       = 2'($urandom_range(0, 3));
                br_taken      = 1'($urandom_range(0, 1));
                branch_target = $urandom & 32'hFFFF_FFFC;
                jr_target     = $urandom & 32'hFFFF_FFFC;
                jmp_pc4       = $urandom & 32'hFFFF_FFFC;
                jmp_addr      = 26'($urandom);
            end
            tick();
            rst = 1'b0;
        end
        vectors++;
        if (pop_cnt - start < 100) begin
            miscompares++;
            $display("FAIL random_liveness: got %0d pops expected at least 100", pop_cnt - start);
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0; epoch = 0; m_pc = RESET_PC;
        fire_cnt = 0; pop_cnt = 0;
        ready_pct = 100; rsp_pct = 100; idr_pct = 100;
        rst = 1'b1; br_taken = 1'b0; jmp_sel = JSEL_SEQ;
        branch_target = '0; jmp_addr = '0; jmp_pc4 = '0; jr_target = '0;
        bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data = '0; bus.id_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_jump();
        test_jr_priority();
        test_reset_mid_and_wrap();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
